// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART with TX/RX byte FIFOs, baud divider and level irq.
// Define UART_LOOPBACK_EN to add CTRL bit4, which routes the TX stream into RX and holds txd high.
module uart_mmio #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] dev_addr,
  input  logic        dev_re,
  output logic [31:0] dev_rd,
  input  logic        dev_we,
  input  logic [31:0] dev_wd,
  input  logic        rxd,
  output logic        txd,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef UART_LOOPBACK_EN
  localparam int CW = 5;
`else
  localparam int CW = 4;
`endif
  localparam logic [AW:0] ONE = 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [7:0] rx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  logic [15:0] div_q;
  logic [CW-1:0] ctrl_q;
  logic [2:0] sticky_q;
  logic irq_q;
  state_t txs_q, txs_d, rxs_q, rxs_d;
  logic [15:0] txc_q, txc_d, rxc_q, rxc_d;
  logic [2:0] txb_q, txb_d, rxb_q, rxb_d;
  logic [7:0] txsh_q, txsh_d, rxsh_q, rxsh_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic prev_q;
  logic tx_empty, tx_full, rx_empty, rx_full, tx_idle;
  logic wr_data, wr_stat, wr_div, wr_ctrl, rx_pop, tx_push, tx_pop, rx_push, fe_set;
  logic tx_line, rx_in;
  logic [16:0] div_p1;
  logic [15:0] half_m1;
  logic [31:0] status;
  logic unused_ok;
  assign tx_empty = tx_wp_q == tx_rp_q;
  assign rx_empty = rx_wp_q == rx_rp_q;
  assign tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
  assign rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
  assign tx_idle  = tx_empty && txs_q == IDLE;
  assign wr_data  = dev_we && dev_addr == 30'd0;
  assign wr_stat  = dev_we && dev_addr == 30'd1;
  assign wr_div   = dev_we && dev_addr == 30'd2;
  assign wr_ctrl  = dev_we && dev_addr == 30'd3;
  assign rx_pop   = dev_re && dev_addr == 30'd0 && !rx_empty;
  assign tx_push  = wr_data && !tx_full;
  assign div_p1   = {1'b0, div_q} + 17'd1;
  assign half_m1  = div_p1[16:1] - 16'd1;
  assign unused_ok = ^{dev_wd[31:16], div_p1[0]};
  assign tx_line  = txs_q == START ? 1'b0 : txs_q == DATA ? txsh_q[0] : 1'b1;
`ifdef UART_LOOPBACK_EN
  assign rx_in = ctrl_q[4] ? tx_line : sync_q[SYNC_STAGES-1];
  assign txd   = ctrl_q[4] ? 1'b1 : tx_line;
`else
  assign rx_in = sync_q[SYNC_STAGES-1];
  assign txd   = tx_line;
`endif
  assign irq    = irq_q;
  assign status = {25'd0, sticky_q, tx_idle, tx_full, rx_full, !rx_empty};
  // Read data depends on the address only, so the bus can merge partial writes with it.
  assign dev_rd = dev_addr == 30'd0 ? {24'd0, rx_empty ? 8'h00 : rx_mem[rx_rp_q[AW-1:0]]} :
                  dev_addr == 30'd1 ? status :
                  dev_addr == 30'd2 ? {16'd0, div_q} :
                  dev_addr == 30'd3 ? 32'(ctrl_q) : 32'd0;
  always_comb begin
    txs_d = txs_q;
    txc_d = txc_q;
    txb_d = txb_q;
    txsh_d = txsh_q;
    tx_pop = 1'b0;
    if (txs_q == IDLE) begin
      if (ctrl_q[0] && !tx_empty) begin
        tx_pop = 1'b1;
        txsh_d = tx_mem[tx_rp_q[AW-1:0]];
        txc_d = div_q;
        txs_d = START;
      end
    end else if (txc_q != 16'd0) begin
      txc_d = txc_q - 16'd1;
    end else begin
      txc_d = div_q;
      case (txs_q)
        START: begin txs_d = DATA; txb_d = 3'd0; end
        DATA: begin
          txsh_d = txsh_q >> 1;
          txb_d = txb_q + 3'd1;
          txs_d = txb_q == 3'd7 ? STOP : DATA;
        end
        default: txs_d = IDLE;
      endcase
    end
  end
  // RX samples mid-bit: half a period after the falling edge, then every full period.
  always_comb begin
    rxs_d = rxs_q;
    rxc_d = rxc_q;
    rxb_d = rxb_q;
    rxsh_d = rxsh_q;
    rx_push = 1'b0;
    fe_set = 1'b0;
    if (!ctrl_q[1]) begin
      rxs_d = IDLE;
    end else if (rxs_q == IDLE) begin
      if (prev_q && !rx_in) begin
        rxs_d = START;
        rxc_d = half_m1;
      end
    end else if (rxc_q != 16'd0) begin
      rxc_d = rxc_q - 16'd1;
    end else begin
      rxc_d = div_q;
      case (rxs_q)
        START: begin rxs_d = rx_in ? IDLE : DATA; rxb_d = 3'd0; end
        DATA: begin
          rxsh_d = {rx_in, rxsh_q[7:1]};
          rxb_d = rxb_q + 3'd1;
          rxs_d = rxb_q == 3'd7 ? STOP : DATA;
        end
        default: begin rxs_d = IDLE; rx_push = rx_in; fe_set = !rx_in; end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q[AW-1:0]] <= dev_wd[7:0];
    if (rx_push && !rx_full) rx_mem[rx_wp_q[AW-1:0]] <= rxsh_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp_q <= '0;
      tx_rp_q <= '0;
      rx_wp_q <= '0;
      rx_rp_q <= '0;
      div_q <= DEFAULT_DIV;
      ctrl_q <= '0;
      sticky_q <= '0;
      irq_q <= 1'b0;
      txs_q <= IDLE;
      txc_q <= '0;
      txb_q <= '0;
      txsh_q <= '0;
      rxs_q <= IDLE;
      rxc_q <= '0;
      rxb_q <= '0;
      rxsh_q <= '0;
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      tx_wp_q <= tx_push ? tx_wp_q + ONE : tx_wp_q;
      tx_rp_q <= tx_pop ? tx_rp_q + ONE : tx_rp_q;
      rx_wp_q <= rx_push && !rx_full ? rx_wp_q + ONE : rx_wp_q;
      rx_rp_q <= rx_pop ? rx_rp_q + ONE : rx_rp_q;
      div_q <= wr_div ? dev_wd[15:0] : div_q;
      ctrl_q <= wr_ctrl ? dev_wd[CW-1:0] : ctrl_q;
      sticky_q <= (sticky_q & ~(wr_stat ? dev_wd[6:4] : 3'd0)) |
                  {wr_data && tx_full, fe_set, rx_push && rx_full};
      irq_q <= (ctrl_q[2] && !rx_empty) || (ctrl_q[3] && tx_idle);
      txs_q <= txs_d;
      txc_q <= txc_d;
      txb_q <= txb_d;
      txsh_q <= txsh_d;
      rxs_q <= rxs_d;
      rxc_q <= rxc_d;
      rxb_q <= rxb_d;
      rxsh_q <= rxsh_d;
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
      prev_q <= rx_in;
    end
  end
endmodule
